// File: rtl/program_memory_loadable_pkg.sv
// Shared definitions for the loadable program memory of the VGA-drawing CPU:
// opcode/register encodings, the NOP fill word and the controller state encoding.
package program_memory_loadable_pkg;

    localparam int unsigned OPCODE_WIDTH  = 4;
    localparam int unsigned OPERAND_WIDTH = 24;

    // Opcode encodings of the drawing CPU
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVE  = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_DRAW  = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = 4'h3;

    // Register selectors used in the operand field
    localparam logic [1:0] REG_X     = 2'd0;
    localparam logic [1:0] REG_Y     = 2'd1;
    localparam logic [1:0] REG_COLOR = 2'd2;

    // Fill word: a NOP whose operand is the idle delay of 4000 cycles
    localparam logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] PROGMEM_NOP_WORD = {OP_NOP, 24'd4000};

    typedef enum logic [1:0] {
        PmClear = 2'd0,
        PmIdle  = 2'd1,
        PmLoad  = 2'd2
    } pm_state_e;

endpackage

// File: rtl/program_memory_loadable_if.sv
// Fetch and loader signals of the program memory. oChecksum exists only when
// PROGMEM_CHECKSUM_EN is defined.
interface program_memory_loadable_if #(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  iRead;
    logic [ADDR_WIDTH-1:0] iAddress;
    logic [DATA_WIDTH-1:0] oInstruction;
    logic                  oValid;
    logic                  oBusy;
    logic                  iLoadStart;
    logic [ADDR_WIDTH-1:0] iLoadBase;
    logic                  iLoadValid;
    logic [DATA_WIDTH-1:0] iLoadData;
    logic                  iLoadLast;
    logic                  oLoadReady;
    logic                  oLoadDone;
    logic                  oLoadError;
`ifdef PROGMEM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] oChecksum;
`endif

    // Memory side
    modport slave (
        input  iRead, iAddress, iLoadStart, iLoadBase, iLoadValid, iLoadData, iLoadLast,
        output oInstruction, oValid, oBusy, oLoadReady, oLoadDone, oLoadError
`ifdef PROGMEM_CHECKSUM_EN
        , output oChecksum
`endif
    );

    // CPU fetch stage / host loader side
    modport master (
        output iRead, iAddress, iLoadStart, iLoadBase, iLoadValid, iLoadData, iLoadLast,
        input  oInstruction, oValid, oBusy, oLoadReady, oLoadDone, oLoadError
`ifdef PROGMEM_CHECKSUM_EN
        , input oChecksum
`endif
    );

endinterface

// File: rtl/program_memory_loadable_prog_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// No reset on the array or read data so it maps onto block RAM.
module program_memory_loadable_prog_ram #(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RAM_AW     = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [RAM_AW-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [RAM_AW-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port; data holds when no read is requested
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/program_memory_loadable.sv
// Writable instruction memory for the VGA-drawing CPU. After reset the whole
// array is cleared to the NOP word, then fetches are served with one cycle of
// latency and a host can stream new programs in over a valid/ready channel.
// Optional feature: define PROGMEM_CHECKSUM_EN to add an XOR checksum output.
module program_memory_loadable
    import program_memory_loadable_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input logic                      Clock,
    input logic                      Reset,
    program_memory_loadable_if.slave bus
);

    localparam int unsigned           RamAw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NopWord  = DATA_WIDTH'(PROGMEM_NOP_WORD);

    pm_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  ptr_at_last;
    logic                  base_ok;
    logic                  addr_ok;
    logic                  start_req;
    logic                  rd_accept;
    logic                  ld_accept;
    logic                  ld_end;

    logic                  busy;
    logic                  ready;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  valid_q;
    logic                  nop_sel_q;
    logic                  done_q;
    logic                  error_q;

    assign ptr_at_last = (ptr_q == LastAddr);
    assign base_ok     = ({1'b0, bus.iLoadBase} < DepthExt);
    assign addr_ok     = ({1'b0, bus.iAddress} < DepthExt);
    assign start_req   = (state_q == PmIdle) && bus.iLoadStart;
    assign rd_accept   = (state_q == PmIdle) && bus.iRead;
    assign ld_accept   = (state_q == PmLoad) && bus.iLoadValid;
    // A session ends on a word flagged last or on a word written to the final address
    assign ld_end      = ld_accept && (bus.iLoadLast || ptr_at_last);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= PmClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PmClear: if (ptr_at_last) state_d = PmIdle;
            // An out-of-range base never enters LOAD; it is reported from IDLE
            PmIdle:  if (start_req && base_ok) state_d = PmLoad;
            PmLoad:  if (ld_end) state_d = PmIdle;
            default: state_d = PmClear;
        endcase
    end

    // State-decoded outputs and RAM write port control
    always_comb begin
        busy      = 1'b1;
        ready     = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = NopWord;
        unique case (state_q)
            PmClear: ram_we = 1'b1;
            PmIdle:  busy = 1'b0;
            PmLoad: begin
                ready     = 1'b1;
                ram_we    = bus.iLoadValid;
                ram_wdata = bus.iLoadData;
            end
            default: ;
        endcase
    end

    // Write pointer: sweeps the array in CLEAR, follows the stream in LOAD, never wraps
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            unique case (state_q)
                PmClear: if (!ptr_at_last) ptr_q <= ptr_q + 1'b1;
                PmIdle:  if (bus.iLoadStart) ptr_q <= bus.iLoadBase;
                PmLoad:  if (ld_accept && !ptr_at_last) ptr_q <= ptr_q + 1'b1;
                default: ptr_q <= '0;
            endcase
        end
    end

    // Read qualifiers; nop_sel_q masks RAM data after reset and for out-of-range fetches
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q   <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            valid_q <= rd_accept;
            if (rd_accept) begin
                nop_sel_q <= !addr_ok;
            end
        end
    end

    // Session status: single-cycle done pulse and sticky overflow/bad-base error
    always_ff @(posedge Clock) begin
        if (Reset) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= ld_end || (start_req && !base_ok);
            if (start_req) begin
                error_q <= !base_ok;
            end else if (ld_accept && ptr_at_last && !bus.iLoadLast) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef PROGMEM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    // Running XOR of accepted load words, restarted by every load request
    always_ff @(posedge Clock) begin
        if (Reset) begin
            csum_q <= '0;
        end else if (start_req) begin
            csum_q <= '0;
        end else if (ld_accept) begin
            csum_q <= csum_q ^ bus.iLoadData;
        end
    end

    assign bus.oChecksum = csum_q;
`endif

    program_memory_loadable_prog_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RAM_AW     (RamAw)
    ) u_prog_ram (
        .clk_i   (Clock),
        .we_i    (ram_we),
        .waddr_i (ptr_q[RamAw-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (rd_accept),
        .raddr_i (bus.iAddress[RamAw-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.oInstruction = nop_sel_q ? NopWord : ram_rdata;
    assign bus.oValid       = valid_q;
    assign bus.oBusy        = busy;
    assign bus.oLoadReady   = ready;
    assign bus.oLoadDone    = done_q;
    assign bus.oLoadError   = error_q;

endmodule
